cnn_window_gen: RTL and testbench

- Raster-scan 3x3 window generator feeding the 3x3 convolution MAC stage.
- Accepts one pixel per beat over AXI4-Stream and buffers two image rows.
- For every valid (no-padding) 3x3 position, emits one 18-lane packet holding 9 window pixels plus the 9 stored kernel coefficients.
- Output packing matches the MAC stage's slave input exactly; frame geometry is fixed by parameters.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/cnn_line_buffer.sv | 29 ++
 rtl/cnn_window_gen.sv | 159 +++++++++++++++
 tb/tb_cnn_window_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, scan states and lane packing helper for the 3x3 window generator
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int NUM_TAPS           = 9;
  localparam int PKT_LANES          = 18;

  typedef enum logic {
    SCAN_FILL   = 1'b0,
    SCAN_STREAM = 1'b1
  } scan_state_e;

  // Lane i of a packet occupies bits [i*width +: width].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// rtl/cnn_line_buffer.sv - two image-row delay lines, read-before-write at the current column
module cnn_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int COL_W      = $clog2(IMG_W)
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [COL_W-1:0]      col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] row0_q,
  output logic [DATA_WIDTH-1:0] row1_q
);

  // lb0 holds the previous row, lb1 the row before that.
  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];

  assign row0_q = lb0[col];
  assign row1_q = lb1[col];

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      lb1[col] <= lb0[col];
      lb0[col] <= wr_data;
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// rtl/cnn_window_gen.sv - raster-scan 3x3 window generator emitting window+kernel packets over AXI-Stream
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            k_we,
  input  logic [3:0]                      k_addr,
  input  logic [DATA_WIDTH-1:0]           k_wdata,
  output logic [DATA_WIDTH*PKT_LANES-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int PKT_W = DATA_WIDTH * PKT_LANES;

  localparam logic [COL_W-1:0] COL_LAST       = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST       = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST_EMIT = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST  = ROW_W'(1);

  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  scan_state_e           state_q;
  scan_state_e           state_d;
  logic                  accept;
  logic                  emit;
  logic                  col_wrap;
  logic                  frame_end;
  logic [DATA_WIDTH-1:0] lb0_q;
  logic [DATA_WIDTH-1:0] lb1_q;
  logic [DATA_WIDTH-1:0] win_q    [NUM_TAPS];
  logic [DATA_WIDTH-1:0] win_d    [NUM_TAPS];
  logic [DATA_WIDTH-1:0] kernel_q [NUM_TAPS];
  logic [PKT_W-1:0]      pkt_d;

  // A stalled output register blocks input, so a held packet never changes.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign col_wrap      = (col_q == COL_LAST);
  assign frame_end     = col_wrap && (row_q == ROW_LAST);

  cnn_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .COL_W      (COL_W)
  ) u_line_buffer (
    .aclk    (aclk),
    .wr_en   (accept),
    .col     (col_q),
    .wr_data (s_axis_tdata),
    .row0_q  (lb0_q),
    .row1_q  (lb1_q)
  );

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r*3]     = win_q[r*3 + 1];
      win_d[r*3 + 1] = win_q[r*3 + 2];
    end
    win_d[2] = lb1_q;
    win_d[5] = lb0_q;
    win_d[8] = s_axis_tdata;
  end

  always_comb begin
    pkt_d = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      pkt_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]            = win_d[i];
      pkt_d[lane_lsb(NUM_TAPS + i, DATA_WIDTH) +: DATA_WIDTH] = kernel_q[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= SCAN_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    case (state_q)
      SCAN_FILL: begin
        if (accept && col_wrap && (row_q == ROW_FILL_LAST)) begin
          state_d = SCAN_STREAM;
        end
      end
      SCAN_STREAM: begin
        emit = accept && (col_q >= COL_FIRST_EMIT);
        if (accept && frame_end) begin
          state_d = SCAN_FILL;
        end
      end
      default: state_d = SCAN_FILL;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Window contents are only meaningful once three columns of the current row are in.
  always_ff @(posedge aclk) begin
    if (accept) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        kernel_q[i] <= '0;
      end
    end else if (k_we && (k_addr < 4'(NUM_TAPS))) begin
      kernel_q[k_addr] <= k_wdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (emit) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= pkt_d;
      m_axis_tlast  <= frame_end;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// tb/tb_cnn_window_gen.sv - randomized and directed bench for cnn_window_gen against a frame-array model
module tb_cnn_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = DW * 18;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          k_we = 1'b0;
  logic [3:0]    k_addr = '0;
  logic [DW-1:0] k_wdata = '0;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;

  cnn_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_H      (H)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .k_we          (k_we),
    .k_addr        (k_addr),
    .k_wdata       (k_wdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] frame_px [H][W];
  logic [DW-1:0] mk [9];
  int            mrow = 0;
  int            mcol = 0;
  logic [PW:0]   exp_q [$];
  logic [PW-1:0] got_q [$];
  logic          got_last_q [$];
  logic          held = 1'b0;
  logic [PW-1:0] held_data;
  logic          held_last;

  task automatic model_accept(input logic [DW-1:0] p);
    logic [PW-1:0] d;
    frame_px[mrow][mcol] = p;
    if (mrow >= 2 && mcol >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          d[(r*3 + c)*DW +: DW] = frame_px[mrow-2+r][mcol-2+c];
      for (int k = 0; k < 9; k++) d[(9 + k)*DW +: DW] = mk[k];
      exp_q.push_back({(mrow == H-1 && mcol == W-1), d});
    end
    if (mcol == W-1) begin
      mcol = 0;
      mrow = (mrow == H-1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  // One clock: drive at the falling edge, observe 1ns later, update the model for the coming rising edge.
  task automatic step(input logic pv, input logic [DW-1:0] pd, input logic rdy,
                      input logic kwe, input logic [3:0] ka, input logic [DW-1:0] kd,
                      output logic acc);
    logic [PW:0] e;
    s_axis_tvalid = pv;
    s_axis_tdata  = pd;
    m_axis_tready = rdy;
    k_we          = kwe;
    k_addr        = ka;
    k_wdata       = kd;
    #1;
    check("s_ready", s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
    if (held) begin
      check("hold_data", m_axis_tdata, held_data);
      check("hold_last", m_axis_tlast, held_last);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      check("pkt_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pkt_data", m_axis_tdata, e[PW-1:0]);
        check("pkt_last", m_axis_tlast, e[PW]);
      end
      got_q.push_back(m_axis_tdata);
      got_last_q.push_back(m_axis_tlast);
    end
    held      = m_axis_tvalid && !m_axis_tready;
    held_data = m_axis_tdata;
    held_last = m_axis_tlast;
    acc = pv && s_axis_tready;
    if (acc) model_accept(pd);
    if (kwe && ka < 9) mk[ka] = kd;
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    k_we          = 1'b0;
    @(negedge aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    aresetn = 1'b1;
    mrow = 0;
    mcol = 0;
    for (int k = 0; k < 9; k++) mk[k] = '0;
    exp_q.delete();
    held = 1'b0;
  endtask

  task automatic load_kernel();
    logic acc;
    for (int k = 0; k < 9; k++) step(1'b0, '0, 1'b1, 1'b1, 4'(k), DW'(k + 1), acc);
  endtask

  task automatic drain();
    logic acc;
    int g = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && g < 50) begin
      step(1'b0, '0, 1'b1, 1'b0, '0, '0, acc);
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Pixel value i%16+1; optional kernel write with pixel kw_at, optional 3-cycle stall after stall_after.
  task automatic send_stream(input int n, input int stall_after, input int kw_at,
                             input logic [3:0] kw_addr, input logic [DW-1:0] kw_data);
    logic acc;
    int i = 0;
    int stall = 0;
    int guard = 0;
    got_q.delete();
    got_last_q.delete();
    while (i < n && guard < 1000) begin
      step(1'b1, DW'((i % 16) + 1), stall == 0, i == kw_at, kw_addr, kw_data, acc);
      if (stall > 0) stall--;
      if (acc) begin
        if (i == stall_after) stall = 3;
        i++;
      end
      guard++;
    end
    check("send_bound", i, n);
    drain();
  endtask

  function automatic logic [PW-1:0] mkpkt(input int p0, input int k4, input bit kzero);
    logic [PW-1:0] d;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        d[(r*3 + c)*DW +: DW] = DW'(p0 + r*W + c);
    for (int k = 0; k < 9; k++)
      d[(9 + k)*DW +: DW] = kzero ? '0 : ((k == 4) ? DW'(k4) : DW'(k + 1));
    return d;
  endfunction

  initial begin
    logic       acc;
    logic [7:0] lastvec;
    for (int k = 0; k < 9; k++) mk[k] = '0;
    repeat (2) @(negedge aclk);
    do_reset();
    check("rst_s_ready", s_axis_tready, 1'b1);

    load_kernel();
    step(1'b0, '0, 1'b1, 1'b1, 4'd12, 8'hEE, acc);

    send_stream(16, -1, -1, '0, '0);
    check("basic_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("basic_pkt0", got_q[0], mkpkt(1, 5, 1'b0));
      check("basic_pkt3", got_q[3], mkpkt(6, 5, 1'b0));
      check("basic_last", {got_last_q[3], got_last_q[2], got_last_q[1], got_last_q[0]}, 4'b1000);
    end

    send_stream(16, 11, 11, 4'd4, 8'hFF);
    check("bp_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("bp_pkt1", got_q[1], mkpkt(2, 5, 1'b0));
      check("bp_pkt2", got_q[2], mkpkt(5, 8'hFF, 1'b0));
    end

    send_stream(32, -1, -1, '0, '0);
    check("b2b_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      check("b2b_pkt4", got_q[4], mkpkt(1, 8'hFF, 1'b0));
      for (int i = 0; i < 8; i++) lastvec[i] = got_last_q[i];
      check("b2b_last", lastvec, 8'b1000_1000);
    end

    for (int i = 0; i < 10; i++) step(1'b1, DW'(i + 1), 1'b1, 1'b0, '0, '0, acc);
    do_reset();
    send_stream(16, -1, -1, '0, '0);
    check("rst_count", got_q.size(), 4);
    if (got_q.size() == 4) check("rst_pkt0_zero_k", got_q[0], mkpkt(1, 0, 1'b1));
    load_kernel();
    send_stream(16, -1, -1, '0, '0);
    if (got_q.size() == 4) begin
      check("reload_pkt0", got_q[0], mkpkt(1, 5, 1'b0));
      check("reload_pkt3", got_q[3], mkpkt(6, 5, 1'b0));
    end

    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), DW'($urandom), acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
